parking_entry_gate: RTL

- Entry-barrier controller that sits directly upstream of the lot occupancy counter.
- Debounces the raw arrival-loop and beam sensors and checks a keypad pass code.
- Sequences the barrier, then issues exactly one entry_pulse per car that fully passes the beam. entry_pulse drives the counter's entry input.
- Consumes the counter's parking_full flag to refuse entry.

---
 rtl/parking_pkg.sv | 12 +
 rtl/parking_entry_gate_sensor_debounce.sv | 34 +++
 rtl/parking_entry_gate.sv | 135 +++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM state encoding, default constants and width helper for the entry gate
package parking_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_CODE, OPEN, PASSING, LOCKOUT} state_t;
  localparam logic [3:0] DEF_PASSCODE     = 4'hA;
  localparam int         DEF_DEBOUNCE_CYC = 4;
  localparam int         DEF_TIMEOUT_CYC  = 1000;
  localparam int         DEF_MAX_TRIES    = 3;
  localparam int         DEF_LOCK_CYC     = 5000;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parking_entry_gate_sensor_debounce.sv
// sensor_debounce: 2-FF synchroniser plus stability counter with one-cycle edge flags on the clean value
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYC);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          w_take;
  assign w_take = (r_sync[1] != clean) && (r_cnt == CW'(DEBOUNCE_CYC - 1));
  // synchronise, count consecutive disagreeing cycles, then adopt the new level and flag the edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      r_cnt  <= (r_sync[1] == clean || w_take) ? '0 : r_cnt + 1'b1;
      clean  <= w_take ? r_sync[1] : clean;
      rise   <= w_take && r_sync[1];
      fall   <= w_take && !r_sync[1];
    end
endmodule

// File: rtl/parking_entry_gate.sv
// parking_entry_gate: debounced entry barrier sequencer feeding the occupancy counter; TRY_LIMIT_EN adds wrong-code lockout
module parking_entry_gate
  import parking_pkg::*;
#(
  parameter logic [3:0] PASSCODE     = DEF_PASSCODE,
  parameter int         DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int         TIMEOUT_CYC  = DEF_TIMEOUT_CYC
`ifdef TRY_LIMIT_EN
  ,
  parameter int         MAX_TRIES    = DEF_MAX_TRIES,
  parameter int         LOCK_CYC     = DEF_LOCK_CYC
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_arrive,
  input  logic       car_beam,
  input  logic       code_valid,
  input  logic [3:0] code_in,
  input  logic       parking_full,
  output logic       gate_open,
  output logic       entry_pulse,
  output logic       full_reject,
  output logic       code_err,
  output logic       busy
);
  localparam int TW = cnt_width(TIMEOUT_CYC);
  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic          w_load, w_expired, w_code_ok, w_full_rej, w_code_err, w_entry;
  logic          w_arr_clean, w_arr_rise, w_arr_fall;
  logic          w_beam_clean, w_beam_rise, w_beam_fall;
  logic          w_unused;
  assign w_unused  = &{1'b0, w_arr_clean, w_beam_clean};
  assign w_code_ok = code_valid && code_in == PASSCODE;
  assign w_expired = r_timer == '0;

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arr (
    .clk(clk), .rst(rst), .raw(car_arrive),
    .clean(w_arr_clean), .rise(w_arr_rise), .fall(w_arr_fall)
  );

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_beam (
    .clk(clk), .rst(rst), .raw(car_beam),
    .clean(w_beam_clean), .rise(w_beam_rise), .fall(w_beam_fall)
  );

`ifdef TRY_LIMIT_EN
  localparam int NW = cnt_width(MAX_TRIES + 1);
  localparam int LW = cnt_width(LOCK_CYC);
  logic [NW-1:0] r_tries;
  logic [LW-1:0] r_lock;
  logic          w_lock_now;
  assign w_lock_now = r_tries == NW'(MAX_TRIES - 1);
  // wrong-code tally and lockout countdown
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_tries <= '0;
      r_lock  <= '0;
    end else begin
      r_tries <= ((r_state == WAIT_CODE && w_code_ok) || (r_state == LOCKOUT && w_next == IDLE)) ? '0 :
                 w_code_err ? r_tries + 1'b1 : r_tries;
      r_lock  <= (w_next == LOCKOUT && r_state != LOCKOUT) ? LW'(LOCK_CYC - 1) :
                 (r_lock != '0) ? r_lock - 1'b1 : r_lock;
    end
`endif

  // state register and saturating timeout countdown
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_load ? TW'(TIMEOUT_CYC - 1) : w_expired ? r_timer : r_timer - 1'b1;
    end

  // next-state and pulse decisions; code strobes take priority over timeout and arrival loss
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_full_rej = 1'b0;
    w_code_err = 1'b0;
    w_entry    = 1'b0;
    case (r_state)
      IDLE:
        if (w_arr_rise) begin
          w_full_rej = parking_full;
          w_load     = !parking_full;
          if (!parking_full) w_next = WAIT_CODE;
        end
      WAIT_CODE:
        if (w_code_ok) begin
          w_full_rej = parking_full;
          w_load     = !parking_full;
          if (parking_full) w_next = IDLE;
          else w_next = OPEN;
        end else if (code_valid) begin
          w_code_err = 1'b1;
`ifdef TRY_LIMIT_EN
          if (w_lock_now) w_next = LOCKOUT;
`endif
        end else if (w_expired || w_arr_fall) w_next = IDLE;
      OPEN:
        if (w_beam_rise) w_next = PASSING;
        else if (w_expired) w_next = IDLE;
      PASSING:
        if (w_beam_fall) begin
          w_next  = IDLE;
          w_entry = 1'b1;
        end
`ifdef TRY_LIMIT_EN
      LOCKOUT:
        if (r_lock == '0) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // registered outputs follow the state being entered
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gate_open   <= 1'b0;
      entry_pulse <= 1'b0;
      full_reject <= 1'b0;
      code_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gate_open   <= w_next == OPEN || w_next == PASSING;
      entry_pulse <= w_entry;
      full_reject <= w_full_rej;
      code_err    <= w_code_err;
      busy        <= w_next != IDLE;
    end
endmodule
